// File: rtl/seq_diff_decoder.sv
// Sequence difference decoder: recovers increments D = S(n) - S(n-1) from an accumulator's running sums.
// Optional macro SEQ_DIFF_WRAP_CHECK_EN registers a borrow flag (S < prev) alongside each result.
module seq_diff_decoder #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic [WIDTH-1:0] s,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] d,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [CNT_W-1:0] count,
    output logic             err
);
    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t           state_reg;
    logic [WIDTH-1:0] prev_reg;
    logic [WIDTH-1:0] d_reg;
    logic             out_valid_reg;
    logic [CNT_W-1:0] count_reg;
    logic             in_xfer;
    logic             out_xfer;
    logic [WIDTH-1:0] prev_eff;

    // The one-entry buffer frees up in the same cycle it is drained.
    assign in_ready = !out_valid_reg || out_ready;
    assign in_xfer  = in_valid && in_ready;
    assign out_xfer = out_valid_reg && out_ready;

    // In IDLE the reference is the reset accumulator value (zero).
    assign prev_eff = (state_reg == RUN) ? prev_reg : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= IDLE;
            prev_reg      <= '0;
            d_reg         <= '0;
            out_valid_reg <= 1'b0;
            count_reg     <= '0;
        end else if (clr) begin
            state_reg     <= IDLE;
            prev_reg      <= '0;
            out_valid_reg <= 1'b0;
            count_reg     <= '0;
        end else if (in_xfer) begin
            state_reg     <= RUN;
            prev_reg      <= s;
            d_reg         <= s - prev_eff;
            out_valid_reg <= 1'b1;
            count_reg     <= count_reg + CNT_W'(1);
        end else if (out_xfer) begin
            out_valid_reg <= 1'b0;
        end
    end

`ifdef SEQ_DIFF_WRAP_CHECK_EN
    logic err_reg;

    // A borrow means the accumulator wrapped or the stream went backwards.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_reg <= 1'b0;
        end else if (clr) begin
            err_reg <= 1'b0;
        end else if (in_xfer) begin
            err_reg <= (s < prev_eff);
        end
    end

    assign err = err_reg;
`else
    assign err = 1'b0;
`endif

    assign d         = d_reg;
    assign out_valid = out_valid_reg;
    assign count     = count_reg;

endmodule

// File: tb/tb_seq_diff_decoder.sv
// Scoreboard bench for seq_diff_decoder: expected increments are queued on acceptance and
// compared when the output is consumed.
module tb_seq_diff_decoder;
    logic       clk;
    logic       rst_n;
    logic       clr;
    logic [7:0] s;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] d;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] count;
    logic       err;

    int checks = 0;
    int errors = 0;

    logic [7:0] exp_d_q[$];
    logic       exp_err_q[$];
    logic [7:0] prev_model;
    logic [7:0] cnt_model;
    logic       mon_en;

    seq_diff_decoder #(.WIDTH(8), .CNT_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .clr(clr), .s(s), .in_valid(in_valid),
        .in_ready(in_ready), .d(d), .out_valid(out_valid), .out_ready(out_ready),
        .count(count), .err(err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Output monitor: a result is consumed at the next posedge when valid and ready.
    always @(negedge clk) begin
        if (mon_en && out_valid && out_ready) begin
            checks++;
            if (exp_d_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_output d=%0d but no result was expected", d);
            end else begin
                logic [7:0] ed;
                logic       ee;
                ed = exp_d_q.pop_front();
                ee = exp_err_q.pop_front();
                if (d !== ed || err !== ee) begin
                    errors++;
                    $display("FAIL output d=%0d err=%0b expected d=%0d err=%0b", d, err, ed, ee);
                end else begin
                    $display("output d=%0d err=%0b ok", d, err);
                end
            end
        end
    end

    task automatic model_reset();
        exp_d_q.delete();
        exp_err_q.delete();
        prev_model = 8'd0;
        cnt_model  = 8'd0;
    endtask

    // Called at posedge+1; returns at posedge+1 after the sample is taken.
    task automatic send(input logic [7:0] val);
        bit done = 0;
        s = val;
        in_valid = 1'b1;
        for (int i = 0; i < 50 && !done; i++) begin
            @(negedge clk);
            if (in_ready) begin
                exp_d_q.push_back(val - prev_model);
`ifdef SEQ_DIFF_WRAP_CHECK_EN
                exp_err_q.push_back(val < prev_model);
`else
                exp_err_q.push_back(1'b0);
`endif
                prev_model = val;
                cnt_model  = cnt_model + 8'd1;
                done = 1;
                $display("input s=%0d accepted", val);
            end
            @(posedge clk);
            #1;
        end
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL send_timeout s=%0d never accepted", val);
        end
    endtask

    task automatic drain();
        in_valid = 1'b0;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0 || exp_d_q.size() != 0) begin
            errors++;
            $display("FAIL drain out_valid=%0b pending=%0d expected out_valid=0 pending=0",
                     out_valid, exp_d_q.size());
        end
        checks++;
        if (count !== cnt_model) begin
            errors++;
            $display("FAIL drain_count count=%0d expected %0d", count, cnt_model);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_clr();
        mon_en = 1'b0;
        in_valid = 1'b0;
        clr = 1'b1;
        @(posedge clk);
        #1;
        clr = 1'b0;
        model_reset();
        mon_en = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; clr = 1'b0; s = 8'd0; in_valid = 1'b0; out_ready = 1'b0;
        mon_en = 1'b0;
        model_reset();
        #3;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || d !== 8'd0 || count !== 8'd0 || err !== 1'b0) begin
            errors++;
            $display("FAIL reset in_ready=%0b out_valid=%0b d=%0d count=%0d err=%0b expected 1 0 0 0 0",
                     in_ready, out_valid, d, count, err);
        end else $display("reset state ok");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        mon_en = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_stream();
        logic [7:0] vals [5] = '{8'd1, 8'd3, 8'd7, 8'd15, 8'd31};
        out_ready = 1'b1;
        foreach (vals[i]) begin
            send(vals[i]);
            checks++;
            if (out_valid !== 1'b1) begin
                errors++;
                $display("FAIL stream_latency out_valid=%0b expected 1 after s=%0d", out_valid, vals[i]);
            end
        end
        in_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0 || count !== 8'd5) begin
            errors++;
            $display("FAIL stream_end out_valid=%0b count=%0d expected 0 5", out_valid, count);
        end
        drain();
    endtask

    task automatic test_stall();
        do_clr();
        out_ready = 1'b1;
        send(8'd3);
        out_ready = 1'b0;
        s = 8'd6;
        in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (in_ready !== 1'b0 || out_valid !== 1'b1 || d !== 8'd3 || count !== 8'd1) begin
                errors++;
                $display("FAIL stall in_ready=%0b out_valid=%0b d=%0d count=%0d expected 0 1 3 1",
                         in_ready, out_valid, d, count);
            end else $display("stall cycle %0d ok", i);
            @(posedge clk);
            #1;
        end
        out_ready = 1'b1;
        send(8'd6);
        drain();
    endtask

    task automatic test_clr();
        do_clr();
        out_ready = 1'b1;
        send(8'd5);
        send(8'd9);
        mon_en = 1'b0;
        clr = 1'b1;
        s = 8'd20;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        clr = 1'b0;
        in_valid = 1'b0;
        model_reset();
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0 || count !== 8'd0 || err !== 1'b0 || d !== 8'd4) begin
            errors++;
            $display("FAIL clr out_valid=%0b count=%0d err=%0b d=%0d expected 0 0 0 4",
                     out_valid, count, err, d);
        end else $display("clr ok");
        mon_en = 1'b1;
        @(posedge clk);
        #1;
        send(8'd3);
        drain();
    endtask

    task automatic test_wrap();
        do_clr();
        out_ready = 1'b1;
        send(8'd250);
        send(8'd4);
        send(8'd9);
        drain();
    endtask

    task automatic test_async_reset();
        do_clr();
        out_ready = 1'b1;
        send(8'd7);
        out_ready = 1'b0;
        s = 8'd8;
        in_valid = 1'b1;
        #2;
        mon_en = 1'b0;
        rst_n = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || d !== 8'd0 || count !== 8'd0 || in_ready !== 1'b1 || err !== 1'b0) begin
            errors++;
            $display("FAIL async_reset out_valid=%0b d=%0d count=%0d in_ready=%0b err=%0b expected 0 0 0 1 0",
                     out_valid, d, count, in_ready, err);
        end else $display("async reset ok");
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        model_reset();
        mon_en = 1'b1;
        send(8'd7);
        drain();
    endtask

    task automatic test_count_wrap();
        int drops = 0;
        do_clr();
        out_ready = 1'b1;
        for (int i = 0; i < 256; i++) begin
            send(8'd0);
            if (out_valid !== 1'b1) drops++;
        end
        checks++;
        if (drops != 0 || count !== 8'd0) begin
            errors++;
            $display("FAIL count_wrap drops=%0d count=%0d expected drops=0 count=0", drops, count);
        end else $display("count wrap ok");
        drain();
    endtask

    initial begin
        test_reset();
        test_stream();
        test_stall();
        test_clr();
        test_wrap();
        test_async_reset();
        test_count_wrap();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
